// File: rtl/fta_bus_pkg.sv
// FTA 64-bit bus command request/response types shared by masters and slaves.
package fta_bus_pkg;

   localparam int unsigned CID_W = 4;
   localparam int unsigned TID_W = 8;

   typedef enum logic [2:0] {
      CLASSIC = 3'd0,
      FIXED   = 3'd1,
      INCR    = 3'd2,
      ERC     = 3'd7
   } fta_cti_t;

   typedef struct packed {
      logic [CID_W-1:0] cid;
      logic [TID_W-1:0] tid;
      logic             cyc;
      logic             we;
      fta_cti_t         cti;
      logic [7:0]       sel;
      logic [31:0]      padr;
      logic [63:0]      dat;
   } fta_cmd_request64_t;

   typedef struct packed {
      logic [CID_W-1:0] cid;
      logic [TID_W-1:0] tid;
      logic             ack;
      logic             err;
      logic             rty;
      logic [63:0]      dat;
   } fta_cmd_response64_t;

endpackage

// File: rtl/led_seq_pkg.sv
// Sequencer state encoding and small helpers.
package led_seq_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_TICK = 2'd1,
      ISSUE     = 2'd2,
      WAIT_ACK  = 2'd3
   } led_seq_state_t;

   // Saturating 8-bit increment for the failed-write counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/led_seq_fta64_if.sv
// Request/response pair between the sequencer and the LED port slave.
interface led_seq_fta64_if;
   import fta_bus_pkg::*;

   fta_cmd_request64_t  req;
   fta_cmd_response64_t resp;

   modport master (output req, input resp);
   modport slave  (input req, output resp);
endinterface

// File: rtl/led_seq_prescaler.sv
// Step-period counter: counts 0..period while running, tick on the terminal count.
module led_seq_prescaler #(
   parameter int unsigned PW = 24
) (
   input  logic          rst,
   input  logic          clk,
   input  logic          run_i,
   input  logic [PW-1:0] period_i,
   output logic          tick_c
);

   logic [PW-1:0] cnt_q, cnt_d;

   assign tick_c = run_i && (cnt_q == period_i);

   // Hold at zero when stopped, wrap to zero on the tick.
   always_comb begin
      cnt_d = '0;
      if (run_i && !tick_c) cnt_d = cnt_q + PW'(1);
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/led_seq_fta64.sv
// LED pattern sequencer: steps a pattern table onto the LED port via single-beat ERC writes.
module led_seq_fta64
   import fta_bus_pkg::*;
   import led_seq_pkg::*;
#(
   parameter int unsigned      NPAT    = 16,
   parameter int unsigned      PW      = 24,
   parameter logic [31:0]      LED_ADR = 32'hFFDC0000,
   parameter logic [CID_W-1:0] CID     = 4'd3,
   parameter logic [7:0]       TMO     = 8'd63
) (
   input  logic                      rst,
   input  logic                      clk,
   input  logic                      en,
   input  logic [PW-1:0]             period,
   input  logic [$clog2(NPAT):0]     pat_len,
   input  logic                      pat_we,
   input  logic [$clog2(NPAT)-1:0]   pat_adr,
   input  logic [7:0]                pat_dat,
   led_seq_fta64_if.master           bus,
   output logic                      busy,
   output logic [$clog2(NPAT)-1:0]   idx,
   output logic [7:0]                err_cnt
);

   localparam int unsigned AW = $clog2(NPAT);
   localparam int unsigned LW = AW + 1;

   led_seq_state_t     state_q, state_d;
   fta_cmd_request64_t req_q, req_d;
   logic               busy_q, busy_d;
   logic [AW-1:0]      idx_q, idx_d;
   logic [7:0]         err_q, err_d;
   logic [TID_W-1:0]   tid_q, tid_d;
   logic [7:0]         tmo_q, tmo_d;
   logic [7:0]         pat_q [NPAT];

   logic run_c, tick_c, match_c, unused_resp_c;

   assign run_c   = (state_q == WAIT_TICK) && en && (pat_len != '0);
   assign match_c = (state_q == WAIT_ACK) && (bus.resp.cid == CID) && (bus.resp.tid == tid_q);
   assign unused_resp_c = ^bus.resp.dat;

   led_seq_prescaler #(.PW(PW)) u_presc (
      .rst      (rst),
      .clk      (clk),
      .run_i    (run_c),
      .period_i (period),
      .tick_c   (tick_c)
   );

   // Pattern table: plain write port, read only when a request is launched.
   always_ff @(posedge clk) begin
      if (pat_we) pat_q[pat_adr] <= pat_dat;
   end

   // Next-state, bookkeeping and registered bus request.
   always_comb begin
      state_d = state_q;
      req_d   = '0;
      idx_d   = idx_q;
      err_d   = err_q;
      tid_d   = tid_q;
      tmo_d   = tmo_q;

      unique case (state_q)
         IDLE: begin
            if (en && (pat_len != '0)) state_d = WAIT_TICK;
         end
         WAIT_TICK: begin
            if (!en || (pat_len == '0)) state_d = IDLE;
            else if (tick_c)            state_d = ISSUE;
         end
         ISSUE: begin
            tmo_d   = '0;
            state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            tmo_d = tmo_q + 8'd1;
            if (match_c && bus.resp.ack) begin
               // Wrap also covers an index stranded past a shortened pat_len.
               if ((LW'(idx_q) + LW'(1)) >= pat_len) idx_d = '0;
               else                                  idx_d = idx_q + AW'(1);
               tid_d   = tid_q + TID_W'(1);
               state_d = en ? WAIT_TICK : IDLE;
            end else if (match_c && bus.resp.err) begin
               err_d   = sat_inc8(err_q);
               tid_d   = tid_q + TID_W'(1);
               state_d = en ? WAIT_TICK : IDLE;
            end else if (match_c && bus.resp.rty) begin
               state_d = ISSUE;
            end else if (tmo_q == TMO) begin
               err_d   = sat_inc8(err_q);
               tid_d   = tid_q + TID_W'(1);
               state_d = en ? WAIT_TICK : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // The request is live only for the single ISSUE cycle.
      if (state_d == ISSUE) begin
         req_d.cyc  = 1'b1;
         req_d.we   = 1'b1;
         req_d.cti  = ERC;
         req_d.sel  = 8'h01;
         req_d.padr = LED_ADR;
         req_d.dat  = {56'd0, pat_q[idx_q]};
         req_d.cid  = CID;
         req_d.tid  = tid_q;
      end

      busy_d = (state_d == ISSUE) || (state_d == WAIT_ACK);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= '0;
         busy_q  <= 1'b0;
         idx_q   <= '0;
         err_q   <= '0;
         tid_q   <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         busy_q  <= busy_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         tid_q   <= tid_d;
         tmo_q   <= tmo_d;
      end
   end

   assign bus.req = req_q;
   assign busy    = busy_q;
   assign idx     = idx_q;
   assign err_cnt = err_q;

endmodule

// File: tb/tb_led_seq_fta64.sv
// Directed bench for led_seq_fta64 with a behavioural LED port responder.
module tb_led_seq_fta64;
   import fta_bus_pkg::*;

   localparam int unsigned PW      = 24;
   localparam logic [31:0] LED_ADR = 32'hFFDC0000;
   localparam logic [3:0]  CID     = 4'd3;
   localparam int          P       = 3;

   logic          clk = 1'b0;
   logic          rst, en, pat_we;
   logic [PW-1:0] period;
   logic [4:0]    pat_len;
   logic [3:0]    pat_adr;
   logic [7:0]    pat_dat;
   logic          busy;
   logic [3:0]    idx;
   logic [7:0]    err_cnt;

   led_seq_fta64_if bus ();

   led_seq_fta64 dut (
      .rst     (rst),
      .clk     (clk),
      .en      (en),
      .period  (period),
      .pat_len (pat_len),
      .pat_we  (pat_we),
      .pat_adr (pat_adr),
      .pat_dat (pat_dat),
      .bus     (bus),
      .busy    (busy),
      .idx     (idx),
      .err_cnt (err_cnt)
   );

   always #5 clk = ~clk;

   int chk_n = 0;
   int err_n = 0;
   int cyc_cnt = 0;

   fta_cmd_request64_t log_req [64];
   int                 log_t   [64];
   int                 log_n = 0;

   // Responder modes: 0 ack, 1 silent, 2 rty then ack, 3 wrong-tid ack then real ack 2 clocks later
   int         rsp_mode = 0;
   int         rty_left = 0;
   int         p_age = 0;
   bit         pend = 1'b0;
   logic [7:0] p_tid = '0;

   logic [7:0] exp_a [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01};

   always @(posedge clk) cyc_cnt++;

   // LED port model, driven on the falling edge so the DUT sees it on the next rising edge.
   always @(negedge clk) begin
      bus.resp = '0;
      if (pend) begin
         p_age++;
         case (rsp_mode)
            0: if (p_age == 1) begin
                  bus.resp.cid = CID; bus.resp.tid = p_tid; bus.resp.ack = 1'b1; pend = 1'b0;
               end
            2: if (p_age == 1) begin
                  bus.resp.cid = CID; bus.resp.tid = p_tid;
                  if (rty_left > 0) begin bus.resp.rty = 1'b1; rty_left--; end
                  else bus.resp.ack = 1'b1;
                  pend = 1'b0;
               end
            3: if (p_age == 1) begin
                  bus.resp.cid = CID; bus.resp.tid = p_tid + 8'd1; bus.resp.ack = 1'b1;
               end else if (p_age == 3) begin
                  bus.resp.cid = CID; bus.resp.tid = p_tid; bus.resp.ack = 1'b1; pend = 1'b0;
               end
            default: ;
         endcase
      end
      if (bus.req.cyc) begin
         pend  = 1'b1;
         p_age = 0;
         p_tid = bus.req.tid;
         if (log_n < 64) begin
            log_req[log_n] = bus.req;
            log_t[log_n]   = cyc_cnt;
         end
         log_n++;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_n++;
      assert (got === exp) else begin
         err_n++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic write_pat(input logic [3:0] a, input logic [7:0] d);
      pat_we = 1'b1; pat_adr = a; pat_dat = d;
      step();
      pat_we = 1'b0;
   endtask

   task automatic wait_log(input int n, input int budget, input string tag);
      int k = 0;
      while (log_n < n && k < budget) begin
         step();
         k++;
      end
      check(tag, 64'(log_n), 64'(n));
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int k = 0;
      while (busy !== 1'b0 && k < budget) begin
         step();
         k++;
      end
      check(tag, 64'(busy), 64'(0));
   endtask

   int t0;
   int base;

   initial begin
      rst = 1'b1; en = 1'b0; pat_we = 1'b0; period = PW'(P);
      pat_len = 5'd4; pat_adr = '0; pat_dat = '0;
      repeat (3) step();
      check("rst_req_zero", 64'(bus.req === fta_cmd_request64_t'('0)), 64'(1));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_idx", 64'(idx), 64'(0));
      check("rst_err", 64'(err_cnt), 64'(0));
      rst = 1'b0;
      step();

      write_pat(4'd0, 8'h01);
      write_pat(4'd1, 8'h02);
      write_pat(4'd2, 8'h04);
      write_pat(4'd3, 8'h08);
      for (int a = 4; a < 16; a++) write_pat(4'(a), 8'hEE);

      // Normal sequencing with acks; drop en in the ISSUE cycle of the fifth write.
      rsp_mode = 0;
      t0 = cyc_cnt;
      en = 1'b1;
      wait_log(5, 100, "A_issues");
      en = 1'b0;
      check("A_first_latency", 64'(log_t[0] - t0), 64'(P + 2));
      check("A_step_gap", 64'(log_t[1] - log_t[0]), 64'(P + 3));
      for (int k = 0; k < 5; k++) begin
         check($sformatf("A_dat%0d", k), log_req[k].dat, {56'd0, exp_a[k]});
         check($sformatf("A_tid%0d", k), 64'(log_req[k].tid), 64'(k));
      end
      check("A_we", 64'(log_req[0].we), 64'(1));
      check("A_cti", 64'(log_req[0].cti), 64'(ERC));
      check("A_sel", 64'(log_req[0].sel), 64'(8'h01));
      check("A_padr", 64'(log_req[0].padr), 64'(LED_ADR));
      check("A_cid", 64'(log_req[0].cid), 64'(CID));
      wait_idle(50, "A_idle");
      repeat (10) step();
      check("A_idx_after_en_drop", 64'(idx), 64'(1));
      check("A_err", 64'(err_cnt), 64'(0));
      check("A_no_more_req", 64'(log_n), 64'(5));

      // Silent responder: every attempt times out.
      rsp_mode = 1;
      base = log_n;
      en = 1'b1;
      wait_log(base + 3, 300, "B_issues");
      en = 1'b0;
      check("B_gap1", 64'(log_t[base+1] - log_t[base]), 64'(69));
      check("B_gap2", 64'(log_t[base+2] - log_t[base+1]), 64'(69));
      check("B_err_mid", 64'(err_cnt), 64'(2));
      check("B_idx_mid", 64'(idx), 64'(1));
      for (int k = 0; k < 3; k++) begin
         check($sformatf("B_dat%0d", k), log_req[base+k].dat, 64'h02);
         check($sformatf("B_tid%0d", k), 64'(log_req[base+k].tid), 64'(5 + k));
      end
      wait_idle(100, "B_idle");
      check("B_err_end", 64'(err_cnt), 64'(3));
      check("B_idx_end", 64'(idx), 64'(1));
      check("B_count", 64'(log_n), 64'(base + 3));

      // One retry, then ack.
      rsp_mode = 2;
      rty_left = 1;
      base = log_n;
      en = 1'b1;
      wait_log(base + 2, 50, "C_issues");
      en = 1'b0;
      check("C_gap", 64'(log_t[base+1] - log_t[base]), 64'(2));
      check("C_tid0", 64'(log_req[base].tid), 64'(8));
      check("C_tid1", 64'(log_req[base+1].tid), 64'(8));
      check("C_dat0", log_req[base].dat, 64'h02);
      check("C_dat1", log_req[base+1].dat, 64'h02);
      wait_idle(20, "C_idle");
      step();
      check("C_idx", 64'(idx), 64'(2));
      check("C_err", 64'(err_cnt), 64'(3));

      // Wrong-tid ack ignored, matching ack two clocks later consumed.
      rsp_mode = 3;
      base = log_n;
      en = 1'b1;
      wait_log(base + 1, 50, "D_issue");
      en = 1'b0;
      check("D_tid", 64'(log_req[base].tid), 64'(9));
      check("D_dat", log_req[base].dat, 64'h04);
      step(); step(); step();
      check("D_busy_after_bad", 64'(busy), 64'(1));
      check("D_idx_after_bad", 64'(idx), 64'(2));
      step();
      check("D_busy_done", 64'(busy), 64'(0));
      check("D_idx_done", 64'(idx), 64'(3));

      // Shortened pat_len: idx 3 with pat_len 2 wraps to 0 on the next ack.
      pat_len = 5'd2;
      rsp_mode = 0;
      base = log_n;
      en = 1'b1;
      wait_log(base + 1, 50, "E_issue");
      en = 1'b0;
      check("E_dat", log_req[base].dat, 64'h08);
      check("E_tid", 64'(log_req[base].tid), 64'(10));
      wait_idle(20, "E_idle");
      check("E_idx_wrap", 64'(idx), 64'(0));

      // pat_len of zero issues nothing.
      pat_len = 5'd0;
      base = log_n;
      en = 1'b1;
      repeat (20) step();
      check("G_no_req", 64'(log_n), 64'(base));
      check("G_busy", 64'(busy), 64'(0));
      en = 1'b0;
      pat_len = 5'd4;
      step();

      // Reset in WAIT_ACK; the late ack afterwards must change nothing.
      rsp_mode = 3;
      base = log_n;
      en = 1'b1;
      wait_log(base + 2, 60, "F_issues");
      check("F_dat", log_req[base+1].dat, 64'h02);
      step();
      check("F_pre_busy", 64'(busy), 64'(1));
      check("F_pre_idx", 64'(idx), 64'(1));
      rst = 1'b1;
      en = 1'b0;
      #1;
      check("F_rst_cyc", 64'(bus.req.cyc), 64'(0));
      check("F_rst_busy", 64'(busy), 64'(0));
      check("F_rst_idx", 64'(idx), 64'(0));
      check("F_rst_err", 64'(err_cnt), 64'(0));
      step();
      rst = 1'b0;
      repeat (8) step();
      check("F_late_idx", 64'(idx), 64'(0));
      check("F_late_err", 64'(err_cnt), 64'(0));
      check("F_late_busy", 64'(busy), 64'(0));
      check("F_late_noreq", 64'(log_n), 64'(base + 2));

      $display("Result: errors=%0d of %0d checks", err_n, chk_n);
      $finish;
   end

endmodule
